// File: rtl/cv32e40p_hwloop_sequencer.sv
// Hardware-loop register sets plus end-of-loop detection.
// Raises a same-cycle jump to the loop start and decrements the iteration counters.
module cv32e40p_hwloop_sequencer #(
  parameter int N_HWLP      = 2,
  parameter int N_HWLP_BITS = (N_HWLP > 1) ? $clog2(N_HWLP) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               hwlp_we_i,
  input  logic [N_HWLP_BITS-1:0]   hwlp_regid_i,
  input  logic [31:0]              hwlp_start_i,
  input  logic [31:0]              hwlp_end_i,
  input  logic [31:0]              hwlp_cnt_i,
  input  logic [31:0]              id_pc_i,
  input  logic                     id_valid_i,
  output logic                     hwlp_jump_o,
  output logic [31:0]              hwlp_target_o,
  output logic [N_HWLP-1:0]        hwlp_active_o,
  output logic [32*N_HWLP-1:0]     hwlp_cnt_o
);

  logic [31:0] start_q [N_HWLP];
  logic [31:0] start_d [N_HWLP];
  logic [31:0] end_q   [N_HWLP];
  logic [31:0] end_d   [N_HWLP];
  logic [31:0] cnt_q   [N_HWLP];
  logic [31:0] cnt_d   [N_HWLP];

  logic [N_HWLP-1:0] match;
  logic [N_HWLP-1:0] loop_hit;
  logic [N_HWLP-1:0] sel_wr;
  logic              shield;

  always_comb begin
    hwlp_jump_o   = 1'b0;
    hwlp_target_o = 32'd0;
    shield        = 1'b0;
    match         = '0;
    loop_hit      = '0;
    sel_wr        = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      start_d[i]  = start_q[i];
      end_d[i]    = end_q[i];
      cnt_d[i]    = cnt_q[i];
      match[i]    = id_valid_i && (id_pc_i == end_q[i]) && (cnt_q[i] != 32'd0);
      loop_hit[i] = match[i] && (cnt_q[i] > 32'd1);
      sel_wr[i]   = (int'(hwlp_regid_i) == i);
    end
    // Walk from the innermost loop; the first jumping loop wins the target and
    // blocks every outer loop from decrementing. Expiring loops do not block.
    for (int i = 0; i < N_HWLP; i++) begin
      if (match[i] && !shield) begin
        cnt_d[i] = cnt_q[i] - 32'd1;
      end
      if (loop_hit[i] && !shield) begin
        hwlp_jump_o   = 1'b1;
        hwlp_target_o = start_q[i];
      end
      shield = shield | loop_hit[i];
    end
    // Register writes take priority over the decrement of the same counter.
    for (int i = 0; i < N_HWLP; i++) begin
      if (sel_wr[i]) begin
        if (hwlp_we_i[0]) start_d[i] = hwlp_start_i;
        if (hwlp_we_i[1]) end_d[i]   = hwlp_end_i;
        if (hwlp_we_i[2]) cnt_d[i]   = hwlp_cnt_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_HWLP; i++) begin
        start_q[i] <= 32'd0;
        end_q[i]   <= 32'd0;
        cnt_q[i]   <= 32'd0;
      end
    end else begin
      for (int i = 0; i < N_HWLP; i++) begin
        start_q[i] <= start_d[i];
        end_q[i]   <= end_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    hwlp_active_o = '0;
    hwlp_cnt_o    = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      hwlp_active_o[i]       = (cnt_q[i] != 32'd0);
      hwlp_cnt_o[32*i +: 32] = cnt_q[i];
    end
  end

endmodule
